// File: rtl/wind_polar_cordic_if.sv
// Handshake/data bundle between the wind speed source and the polar converter.
// master drives speed samples; slave returns magnitude/direction and status.
interface wind_polar_cordic_if;
  logic               speeden;
  logic signed [15:0] speedX;
  logic signed [15:0] speedY;
  logic        [15:0] windmag;
  logic        [15:0] winddir;
  logic               dirvalid;
  logic               busy;

  modport master (
    output speeden, speedX, speedY,
    input  windmag, winddir, dirvalid, busy
  );

  modport slave (
    input  speeden, speedX, speedY,
    output windmag, winddir, dirvalid, busy
  );
endinterface

// File: rtl/wind_polar_cordic.sv
// Iterative vectoring CORDIC: speedX/speedY -> windmag/winddir, one micro-rotation per clock.
// Optional WINDDIR_DEGREES_EN: winddir reported in 0.01 degree units with one extra cycle.
module wind_polar_cordic #(
  parameter int NITER = 14,
  parameter int IW    = 22
) (
  input  logic               clock,
  input  logic               reset,
  wind_polar_cordic_if.slave bus
);

`ifdef WINDDIR_DEGREES_EN
  typedef enum logic [2:0] {IDLE, ROTATE, SCALE, DEGREE, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, ROTATE, SCALE, DONE} state_t;
`endif

  localparam logic [15:0] ATAN [0:13] = '{
    16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163,
    16'd81,   16'd41,   16'd20,   16'd10,   16'd5,   16'd3,   16'd1
  };

  state_t state_reg, state_next;

  logic signed [IW-1:0] x_reg, y_reg;
  logic        [15:0]   z_reg;
  logic        [3:0]    iter_reg;
  logic                 zero_reg;
  logic        [15:0]   windmag_reg, winddir_reg;
  logic                 dirvalid_reg;

  logic signed [IW-1:0] x_ext, y_ext, x_sh, y_sh;
  logic        [15:0]   atan_i;
  logic        [IW-1:0] x_pos;
  logic        [IW+15:0] prod, mag_wide;
  logic        [15:0]   mag_sat;
  logic        [15:0]   bam;

  // Guard bits are appended after sign extension, so negating -32768 stays in range.
  assign x_ext  = {{(IW-18){bus.speedX[15]}}, bus.speedX, 2'b00};
  assign y_ext  = {{(IW-18){bus.speedY[15]}}, bus.speedY, 2'b00};
  assign x_sh   = x_reg >>> iter_reg;
  assign y_sh   = y_reg >>> iter_reg;
  assign atan_i = ATAN[iter_reg];

  // Gain compensation 0.607253 in Q15, drops the 2 guard bits, rounds half up.
  assign x_pos    = x_reg[IW-1] ? '0 : x_reg;
  assign prod     = (IW+16)'(x_pos) * (IW+16)'(19898) + (IW+16)'(65536);
  assign mag_wide = prod >> 17;
  assign mag_sat  = (|mag_wide[IW+15:16]) ? 16'hFFFF : mag_wide[15:0];
  assign bam      = zero_reg ? 16'h0000 : z_reg;

`ifdef WINDDIR_DEGREES_EN
  logic [15:0] mag_hold_reg, bam_hold_reg, deg;
  logic [32:0] deg_prod, deg_shift;

  assign deg_prod  = {17'd0, bam_hold_reg} * 33'd36000 + 33'd32768;
  assign deg_shift = deg_prod >> 16;
  assign deg       = (deg_shift >= 33'd36000) ? 16'd0 : deg_shift[15:0];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (bus.speeden) state_next = ROTATE;
      ROTATE: if (iter_reg == 4'(NITER-1)) state_next = SCALE;
`ifdef WINDDIR_DEGREES_EN
      SCALE:  state_next = DEGREE;
      DEGREE: state_next = DONE;
`else
      SCALE:  state_next = DONE;
`endif
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_reg        <= '0;
      y_reg        <= '0;
      z_reg        <= '0;
      iter_reg     <= '0;
      zero_reg     <= 1'b0;
      windmag_reg  <= '0;
      winddir_reg  <= '0;
      dirvalid_reg <= 1'b0;
`ifdef WINDDIR_DEGREES_EN
      mag_hold_reg <= '0;
      bam_hold_reg <= '0;
`endif
    end else begin
      dirvalid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.speeden) begin
            x_reg    <= bus.speedX[15] ? -x_ext : x_ext;
            y_reg    <= bus.speedX[15] ? -y_ext : y_ext;
            z_reg    <= bus.speedX[15] ? 16'h8000 : 16'h0000;
            iter_reg <= '0;
            zero_reg <= (bus.speedX == 16'sd0) && (bus.speedY == 16'sd0);
          end
        end
        ROTATE: begin
          if (!y_reg[IW-1]) begin
            x_reg <= x_reg + y_sh;
            y_reg <= y_reg - x_sh;
            z_reg <= z_reg + atan_i;
          end else begin
            x_reg <= x_reg - y_sh;
            y_reg <= y_reg + x_sh;
            z_reg <= z_reg - atan_i;
          end
          iter_reg <= iter_reg + 4'd1;
        end
`ifdef WINDDIR_DEGREES_EN
        SCALE: begin
          mag_hold_reg <= mag_sat;
          bam_hold_reg <= bam;
        end
        DEGREE: begin
          windmag_reg  <= mag_hold_reg;
          winddir_reg  <= deg;
          dirvalid_reg <= 1'b1;
        end
`else
        SCALE: begin
          windmag_reg  <= mag_sat;
          winddir_reg  <= bam;
          dirvalid_reg <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.windmag  = windmag_reg;
  assign bus.winddir  = winddir_reg;
  assign bus.dirvalid = dirvalid_reg;
  assign bus.busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_wind_polar_cordic.sv
// Directed bench for wind_polar_cordic: hand-computed polar results with CORDIC tolerances,
// latency, pulse width, busy, back-to-back rejection and mid-conversion reset.
module tb_wind_polar_cordic;
  localparam int NITER = 14;
`ifdef WINDDIR_DEGREES_EN
  localparam int LAT    = NITER + 3;
  localparam int DIRMOD = 36000;
  localparam int DTOL   = 3;
`else
  localparam int LAT    = NITER + 2;
  localparam int DIRMOD = 65536;
  localparam int DTOL   = 3;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  wind_polar_cordic_if bus();

  wind_polar_cordic #(.NITER(NITER), .IW(22)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #250 clock = ~clock;

  // Compares got against exp within tol; modulus > 0 makes the distance circular.
  task automatic check(input string tag, input int got, input int exp, input int tol, input int modulus);
    int diff;
    diff = got - exp;
    if (modulus > 0) begin
      diff = diff % modulus;
      if (diff < 0) diff += modulus;
      if (diff > modulus / 2) diff -= modulus;
    end
    if (diff < 0) diff = -diff;
    checks++;
    if (diff > tol) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) tol %0d", tag, got, got, exp, exp, tol);
    end
  endtask

  function automatic int exp_dir(input int ebam);
`ifdef WINDDIR_DEGREES_EN
    longint t;
    t = (longint'(ebam) * 36000 + 32768) / 65536;
    return int'(t % 36000);
`else
    return ebam;
`endif
  endfunction

  task automatic run_conv(input string tag, input logic signed [15:0] xs, input logic signed [15:0] ys,
                          input int emag, input int ebam, input int mtol, input int dtol);
    int cnt;
    @(negedge clock);
    bus.speeden = 1'b1;
    bus.speedX  = xs;
    bus.speedY  = ys;
    @(negedge clock);
    bus.speeden = 1'b0;
    cnt = 1;
    check({tag, "_busy"}, int'(bus.busy), 1, 0, 0);
    while (!bus.dirvalid && cnt < 100) begin
      @(negedge clock);
      cnt++;
    end
    check({tag, "_lat"}, cnt, LAT, 0, 0);
    check({tag, "_mag"}, int'(bus.windmag), emag, mtol, 0);
    check({tag, "_dir"}, int'(bus.winddir), exp_dir(ebam), dtol, DIRMOD);
    @(negedge clock);
    check({tag, "_pulse"}, int'(bus.dirvalid), 0, 0, 0);
    check({tag, "_idle"}, int'(bus.busy), 0, 0, 0);
    $display("conv %s: X=%0d Y=%0d -> mag=%0d dir=%0d latency=%0d", tag, xs, ys, bus.windmag, bus.winddir, cnt);
  endtask

  initial begin
    int pulses, first_at, hold_mag, hold_dir;
    bus.speeden = 1'b0;
    bus.speedX  = '0;
    bus.speedY  = '0;
    repeat (3) @(negedge clock);
    check("rst_mag",   int'(bus.windmag),  0, 0, 0);
    check("rst_dir",   int'(bus.winddir),  0, 0, 0);
    check("rst_valid", int'(bus.dirvalid), 0, 0, 0);
    check("rst_busy",  int'(bus.busy),     0, 0, 0);
    reset = 1'b0;

    run_conv("px",   16'sh0400,  16'sh0000, 1024,  0,     2, DTOL);
    run_conv("py",   16'sh0000,  16'sh0400, 1024,  16384, 2, DTOL);
    run_conv("nx",  -16'sh0400,  16'sh0000, 1024,  32768, 2, DTOL);
    run_conv("q4",   16'sh0400, -16'sh0400, 1448,  57344, 2, DTOL);
    run_conv("min",  16'sh8000,  16'sh8000, 46341, 40960, 2, DTOL);
    run_conv("zero", 16'sh0000,  16'sh0000, 0,     0,     0, 0);
    run_conv("q1",   16'sh0300,  16'sh0400, 1280,  9672,  2, DTOL);
    run_conv("q2",  -16'sh0300,  16'sh0400, 1280,  23096, 2, DTOL);

    // Second strobe three clocks after the first must be ignored.
    @(negedge clock);
    bus.speeden = 1'b1;
    bus.speedX  = 16'sh0400;
    bus.speedY  = -16'sh0400;
    pulses   = 0;
    first_at = 0;
    hold_mag = 0;
    hold_dir = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (bus.dirvalid) begin
        pulses++;
        if (first_at == 0) begin
          first_at = c;
          hold_mag = int'(bus.windmag);
          hold_dir = int'(bus.winddir);
        end
      end
      bus.speeden = (c == 3);
      if (c == 3) begin
        bus.speedX = 16'sh0000;
        bus.speedY = 16'sh0400;
      end
    end
    check("b2b_pulses", pulses,   1,    0, 0);
    check("b2b_lat",    first_at, LAT,  0, 0);
    check("b2b_mag",    hold_mag, 1448, 2, 0);
    check("b2b_dir",    hold_dir, exp_dir(57344), DTOL, DIRMOD);
    $display("b2b: pulses=%0d first_at=%0d mag=%0d dir=%0d", pulses, first_at, hold_mag, hold_dir);

    // Reset during ROTATE iteration 5 aborts the conversion.
    @(negedge clock);
    bus.speeden = 1'b1;
    bus.speedX  = 16'sh0300;
    bus.speedY  = 16'sh0400;
    @(negedge clock);
    bus.speeden = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_mag",   int'(bus.windmag),  0, 0, 0);
    check("abort_dir",   int'(bus.winddir),  0, 0, 0);
    check("abort_busy",  int'(bus.busy),     0, 0, 0);
    check("abort_valid", int'(bus.dirvalid), 0, 0, 0);
    @(negedge clock);
    reset  = 1'b0;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (bus.dirvalid) pulses++;
    end
    check("abort_nopulse", pulses, 0, 0, 0);
    $display("abort: stray pulses=%0d", pulses);
    run_conv("after", 16'sh0300, 16'sh0400, 1280, 9672, 2, DTOL);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
